// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the MMIO timer responder.
// Register offsets, CONTROL bit indices, bus FSM states.
package mmio_timer_responder_pkg;

  localparam logic [1:0] TMR_COUNT   = 2'd0;
  localparam logic [1:0] TMR_COMPARE = 2'd1;
  localparam logic [1:0] TMR_CONTROL = 2'd2;
  localparam logic [1:0] TMR_STATUS  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/mmio_timer_responder_prescaler.sv
// Prescale counter: one tick every PRESCALE enabled cycles.
// Holds its value while disabled; clear forces it back to zero.
module timer_prescaler #(
  parameter int PRESCALE = 50
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable & (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mmio_timer_responder.sv
// MMIO timer peripheral: Read/Write/Ack responder with prescaled
// counter, compare match, optional auto-reload and level interrupt.
module mmio_timer_responder
  import mmio_timer_responder_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  Address,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        Interrupt
);

  bus_state_e       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] compare;
  logic [2:0]       control;
  logic             match;

  logic        tick;
  logic        req;
  logic        access;
  logic        wr;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_control;
  logic        wr_status;
  logic        hit;
  logic [31:0] rdata;

  assign req        = Read | Write;
  assign access     = (state == ST_IDLE) & req;
  assign wr         = access & Write;
  assign wr_count   = wr & (Address == TMR_COUNT);
  assign wr_compare = wr & (Address == TMR_COMPARE);
  assign wr_control = wr & (Address == TMR_CONTROL);
  assign wr_status  = wr & (Address == TMR_STATUS);

  // A software COUNT write on a tick edge suppresses match evaluation.
  assign hit = tick & (count == compare) & ~wr_count;

  assign Interrupt = match & control[CTRL_IRQ];

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (control[CTRL_EN]),
    .clear   (wr_count | wr_control),
    .tick    (tick)
  );

  always_comb begin
    rdata = '0;
    unique case (Address)
      TMR_COUNT:   rdata = 32'(count);
      TMR_COMPARE: rdata = 32'(compare);
      TMR_CONTROL: rdata = {29'd0, control};
      TMR_STATUS:  rdata = {31'd0, match};
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      Ack     <= 1'b0;
      DataOut <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            Ack     <= 1'b1;
            DataOut <= Write ? 32'd0 : rdata;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!req) begin
            Ack     <= 1'b0;
            DataOut <= '0;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      compare <= '1;
      control <= '0;
      match   <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= DataIn[WIDTH-1:0];
      end else if (tick) begin
        count <= (hit & control[CTRL_RELOAD]) ? '0 : count + WIDTH'(1);
      end
      if (wr_compare) begin
        compare <= DataIn[WIDTH-1:0];
      end
      if (wr_control) begin
        control <= DataIn[2:0];
      end
      // Set beats a same-edge W1C clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status & DataIn[0]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder.
// Instance 0: WIDTH=32, instance 1: WIDTH=8; both PRESCALE=2.
module tb_mmio_timer_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addr [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        irq  [2];

  int tests = 0;
  int fails = 0;
  logic [31:0] q;

  always #5 clock = ~clock;

  mmio_timer_responder #(
    .WIDTH    (32),
    .PRESCALE (2)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Address   (addr[0]),
    .Read      (rd[0]),
    .Write     (wr[0]),
    .DataIn    (din[0]),
    .DataOut   (dout[0]),
    .Ack       (ack[0]),
    .Interrupt (irq[0])
  );

  mmio_timer_responder #(
    .WIDTH    (8),
    .PRESCALE (2)
  ) u_dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .Address   (addr[1]),
    .Read      (rd[1]),
    .Write     (wr[1]),
    .DataIn    (din[1]),
    .DataOut   (dout[1]),
    .Ack       (ack[1]),
    .Interrupt (irq[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input int d, input logic r, input logic w,
                        input logic [1:0] a, input logic [31:0] v,
                        output logic [31:0] rq);
    int n = 0;
    addr[d] = a;
    din[d]  = v;
    rd[d]   = r;
    wr[d]   = w;
    do begin
      step();
      n++;
    end while (!ack[d] && n < 8);
    check("ack_rise", 32'(ack[d]), 32'd1);
    rq    = dout[d];
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    step();
    check("ack_fall", 32'(ack[d]), 32'd0);
  endtask

  task automatic wr_reg(input int d, input logic [1:0] a,
                        input logic [31:0] v);
    logic [31:0] unused_q;
    access(d, 1'b0, 1'b1, a, v, unused_q);
  endtask

  task automatic rd_reg(input int d, input logic [1:0] a,
                        output logic [31:0] rq);
    access(d, 1'b1, 1'b0, a, 32'd0, rq);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      rd[i]   = 1'b0;
      wr[i]   = 1'b0;
      din[i]  = '0;
    end

    // reset state
    #12;
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_dout", dout[0], 32'd0);
    check("rst_irq", 32'(irq[0]), 32'd0);
    check("rst_ack8", 32'(ack[1]), 32'd0);
    reset_n = 1'b1;
    step();
    rd_reg(0, 2'd1, q);
    check("rst_compare", q, 32'hFFFF_FFFF);
    rd_reg(0, 2'd0, q);
    check("rst_count", q, 32'd0);
    rd_reg(0, 2'd2, q);
    check("rst_control", q, 32'd0);
    rd_reg(0, 2'd3, q);
    check("rst_status", q, 32'd0);
    rd_reg(1, 2'd1, q);
    check("rst_compare8", q, 32'h0000_00FF);

    // held write: Ack high for 5 cycles, low 1 cycle after release
    addr[0] = 2'd1;
    din[0]  = 32'd7;
    wr[0]   = 1'b1;
    check("hs_ack_pre", 32'(ack[0]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("hs_ack_hi", 32'(ack[0]), 32'd1);
    end
    wr[0] = 1'b0;
    step();
    check("hs_ack_lo", 32'(ack[0]), 32'd0);
    rd_reg(0, 2'd1, q);
    check("hs_compare", q, 32'd7);

    // 8-bit wrap: FF -> 00 on next tick, no match
    wr_reg(1, 2'd1, 32'h10);
    wr_reg(1, 2'd0, 32'hFF);
    wr_reg(1, 2'd2, 32'd1);
    step();
    rd_reg(1, 2'd0, q);
    check("wrap_count", q, 32'd0);
    rd_reg(1, 2'd3, q);
    check("wrap_status", q, 32'd0);
    check("wrap_irq", 32'(irq[1]), 32'd0);

    // match on tick 4 with auto-reload
    wr_reg(0, 2'd1, 32'd3);
    wr_reg(0, 2'd2, 32'h7);
    repeat (6) step();
    check("match_irq_pre", 32'(irq[0]), 32'd0);
    step();
    check("match_irq", 32'(irq[0]), 32'd1);
    rd_reg(0, 2'd0, q);
    check("match_reload", q, 32'd0);

    // plain W1C clear, then clear racing a new match
    wr_reg(0, 2'd3, 32'd1);
    check("w1c_irq_clr", 32'(irq[0]), 32'd0);
    repeat (3) step();
    wr_reg(0, 2'd3, 32'd1);
    check("w1c_race_irq", 32'(irq[0]), 32'd1);
    rd_reg(0, 2'd3, q);
    check("w1c_race_status", q, 32'd1);

    // held COUNT write applies once; counter keeps ticking
    addr[0] = 2'd0;
    din[0]  = 32'd100;
    wr[0]   = 1'b1;
    repeat (5) step();
    wr[0] = 1'b0;
    step();
    rd_reg(0, 2'd0, q);
    check("held_count", q, 32'd102);

    // reset in the middle of a read
    addr[0] = 2'd1;
    rd[0]   = 1'b1;
    step();
    check("mid_ack", 32'(ack[0]), 32'd1);
    check("mid_dout", dout[0], 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack[0]), 32'd0);
    check("mid_rst_dout", dout[0], 32'd0);
    check("mid_rst_irq", 32'(irq[0]), 32'd0);
    #2 reset_n = 1'b1;
    step();
    check("reack_ack", 32'(ack[0]), 32'd1);
    check("reack_dout", dout[0], 32'hFFFF_FFFF);
    rd[0] = 1'b0;
    step();
    check("reack_ack_lo", 32'(ack[0]), 32'd0);
    check("reack_dout_lo", dout[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
